// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Package : dm_pkg
// Brief   : Shared access-type codes, controller states and alignment helpers.
// Rev     : 1.0  initial release
// ============================================================================
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WAIT = 3'd1,
        LD_LO   = 3'd2,
        LD_HI   = 3'd3,
        ST_HI   = 3'd4
    } dm_state_t;

    // Lane mask of the access before shifting; reserved codes behave as word.
    function automatic logic [3:0] base_mask(input logic [2:0] dmt);
        case (dmt)
            DM_HALF, DM_HALF_U: base_mask = 4'b0011;
            DM_BYTE, DM_BYTE_U: base_mask = 4'b0001;
            default:            base_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] dmt, input logic [1:0] off);
        case (dmt)
            DM_HALF, DM_HALF_U: is_misaligned = (off == 2'd3);
            DM_BYTE, DM_BYTE_U: is_misaligned = 1'b0;
            default:            is_misaligned = (off != 2'd0);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : dmem_ctrl_if
// Brief     : MEM-stage request/response bundle between CPU and dmem_ctrl.
// Rev       : 1.0  initial release
// ============================================================================
interface dmem_ctrl_if;

    logic        req;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dmtype;
    logic [31:0] rdata;
    logic        stall;

    modport master (
        output req, mem_w, addr, wdata, dmtype,
        input  rdata, stall
    );

    modport slave (
        input  req, mem_w, addr, wdata, dmtype,
        output rdata, stall
    );

endinterface
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// ============================================================================
// Module : dm_lane_align
// Brief  : Store lane shift/enable generation and load extract/extend path.
// Rev    : 1.0  initial release
// ============================================================================
module dm_lane_align (
    input  logic [2:0]  dmtype,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [31:0] st_lo_data,
    output logic [31:0] st_hi_data,
    output logic [3:0]  st_lo_we,
    output logic [3:0]  st_hi_we,
    output logic [31:0] ld_data
);
    import dm_pkg::*;

    logic [63:0] w_st_wide;
    logic [7:0]  w_we_wide;
    logic [63:0] w_ld_wide;
    logic [31:0] w_ld_win;
    logic        w_unused_ld;

    // Upper halves of the 64-bit views carry whatever spills into the next word.
    assign w_st_wide  = {32'd0, wdata} << {offset, 3'b000};
    assign w_we_wide  = {4'd0, base_mask(dmtype)} << offset;
    assign st_lo_data = w_st_wide[31:0];
    assign st_hi_data = w_st_wide[63:32];
    assign st_lo_we   = w_we_wide[3:0];
    assign st_hi_we   = w_we_wide[7:4];

    assign w_ld_wide   = {hi_word, lo_word} >> {offset, 3'b000};
    assign w_ld_win    = w_ld_wide[31:0];
    assign w_unused_ld = ^w_ld_wide[63:32];

    always_comb begin
        ld_data = w_ld_win;
        case (dmtype)
            DM_HALF:   ld_data = {{16{w_ld_win[15]}}, w_ld_win[15:0]};
            DM_HALF_U: ld_data = {16'd0, w_ld_win[15:0]};
            DM_BYTE:   ld_data = {{24{w_ld_win[7]}}, w_ld_win[7:0]};
            DM_BYTE_U: ld_data = {24'd0, w_ld_win[7:0]};
            default:   ld_data = w_ld_win;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dmem_ctrl
// Brief  : MEM-stage data-memory controller with alignment and split accesses.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_ctrl #(
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            reset,
    dmem_ctrl_if.slave      cpu,
    output logic            sram_en,
    output logic [3:0]      sram_we,
    output logic [AW-1:0]   sram_addr,
    output logic [31:0]     sram_wdata,
    input  logic [31:0]     sram_rdata
);
    import dm_pkg::*;

    dm_state_t   r_state;
    logic [31:0] r_lo_q;

    logic [1:0]    w_off;
    logic [AW-1:0] w_word;
    logic [AW-1:0] w_word_nx;
    logic          w_mis;
    logic [31:0]   w_lo_word;
    logic [31:0]   w_hi_word;
    logic [31:0]   w_st_lo_data;
    logic [31:0]   w_st_hi_data;
    logic [3:0]    w_st_lo_we;
    logic [3:0]    w_st_hi_we;
    logic [31:0]   w_ld_data;
    logic          w_unused_addr;

    assign w_off         = cpu.addr[1:0];
    assign w_word        = cpu.addr[AW+1:2];
    assign w_word_nx     = w_word + AW'(1);
    assign w_mis         = is_misaligned(cpu.dmtype, w_off);
    assign w_unused_addr = ^cpu.addr[31:AW+2];

    // Single-word loads complete in LD_WAIT with the word in the low half.
    assign w_lo_word = (r_state == LD_HI) ? r_lo_q : sram_rdata;
    assign w_hi_word = (r_state == LD_HI) ? sram_rdata : 32'd0;

    dm_lane_align u_align (
        .dmtype     (cpu.dmtype),
        .offset     (w_off),
        .wdata      (cpu.wdata),
        .lo_word    (w_lo_word),
        .hi_word    (w_hi_word),
        .st_lo_data (w_st_lo_data),
        .st_hi_data (w_st_hi_data),
        .st_lo_we   (w_st_lo_we),
        .st_hi_we   (w_st_hi_we),
        .ld_data    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_lo_q  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu.req) begin
                        if (cpu.mem_w) r_state <= w_mis ? ST_HI : IDLE;
                        else           r_state <= w_mis ? LD_LO : LD_WAIT;
                    end
                end
                LD_LO: begin
                    r_lo_q  <= sram_rdata;
                    r_state <= LD_HI;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is low so an abandoned split never issues.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'd0;
        cpu.rdata  = 32'd0;
        cpu.stall  = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (cpu.req) begin
                        sram_en   = 1'b1;
                        sram_addr = w_word;
                        if (cpu.mem_w) begin
                            sram_we    = w_st_lo_we;
                            sram_wdata = w_st_lo_data;
                            cpu.stall  = w_mis;
                        end else begin
                            cpu.stall  = 1'b1;
                        end
                    end
                end
                ST_HI: begin
                    sram_en    = 1'b1;
                    sram_addr  = w_word_nx;
                    sram_we    = w_st_hi_we;
                    sram_wdata = w_st_hi_data;
                end
                LD_LO: begin
                    sram_en   = 1'b1;
                    sram_addr = w_word_nx;
                    cpu.stall = 1'b1;
                end
                LD_WAIT, LD_HI: begin
                    cpu.rdata = w_ld_data;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_dmem_ctrl
// Brief  : Directed plus random bench for dmem_ctrl against a byte-array model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_ctrl;
    import dm_pkg::*;

    localparam int AW = 4;
    localparam int NW = 1 << AW;
    localparam int NB = 4 * NW;

    logic          clk = 1'b0;
    logic          reset;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    dmem_ctrl_if cpu_if();

    dmem_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpu_if),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Word-wide synchronous SRAM with byte enables and registered read data.
    logic [31:0] sram_mem [0:NW-1];
    always @(posedge clk) begin
        if (sram_en) begin
            for (int l = 0; l < 4; l++)
                if (sram_we[l]) sram_mem[sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
            sram_rdata <= sram_mem[sram_addr];
        end
    end

    // Reference: flat little-endian byte memory, address taken modulo its size.
    logic [7:0] ref_mem [0:NB-1];

    int total = 0;
    int bad   = 0;

    logic          snap_en   [0:1];
    logic [AW-1:0] snap_addr [0:1];
    logic [3:0]    snap_we   [0:1];
    logic [31:0]   snap_wd   [0:1];

    function automatic int size_of(input logic [2:0] dt);
        if (dt == DM_BYTE || dt == DM_BYTE_U) return 1;
        if (dt == DM_HALF || dt == DM_HALF_U) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] dt);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = size_of(dt);
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(a + 32'(k)) % NB];
        if (dt == DM_HALF && v[15]) v[31:16] = 16'hFFFF;
        if (dt == DM_BYTE && v[7])  v[31:8]  = 24'hFFFFFF;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input int n);
        for (int k = 0; k < n; k++) ref_mem[(a + 32'(k)) % NB] = wd[8*k +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] dt, output logic [31:0] got,
                             output int cyc, output logic done);
        cpu_if.req    = 1'b1;
        cpu_if.mem_w  = mw;
        cpu_if.addr   = a;
        cpu_if.wdata  = wd;
        cpu_if.dmtype = dt;
        cyc  = 0;
        done = 1'b0;
        got  = 32'd0;
        for (int i = 0; i < 6 && !done; i++) begin
            @(negedge clk);
            if (i < 2) begin
                snap_en[i]   = sram_en;
                snap_addr[i] = sram_addr;
                snap_we[i]   = sram_we;
                snap_wd[i]   = sram_wdata;
            end
            if (!cpu_if.stall) begin
                done = 1'b1;
                got  = cpu_if.rdata;
            end else begin
                cyc++;
                chk("rdata_while_stalled", cpu_if.rdata, 32'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic access(input string tag, input logic mw, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] dt, output logic [31:0] rd);
        int   cyc, n, exp_cyc;
        logic done, mis;
        logic [31:0] exp_rd;
        exp_rd = model_load(a, dt);
        do_access(mw, a, wd, dt, rd, cyc, done);
        n   = size_of(dt);
        mis = (n > 1) && ((int'(a[1:0]) + n) > 4);
        exp_cyc = mw ? (mis ? 1 : 0) : (mis ? 2 : 1);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(cyc), 32'(exp_cyc));
        if (mw) model_store(a, wd, n);
        else    chk({tag, "_rdata"}, rd, exp_rd);
    endtask

    task automatic idle_cycle();
        cpu_if.req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        reset         = 1'b0;
        cpu_if.req    = 1'b0;
        cpu_if.mem_w  = 1'b0;
        cpu_if.addr   = 32'd0;
        cpu_if.wdata  = 32'd0;
        cpu_if.dmtype = DM_WORD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(cpu_if.stall), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_wdata", sram_wdata, 32'd0);
        chk("rst_rdata", cpu_if.rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int w = 0; w < NW; w++) access("init", 1'b1, 32'(4 * w), $urandom, DM_WORD, rd);

        access("st_aligned", 1'b1, 32'h10, 32'h11223344, DM_WORD, rd);
        chk("st_aligned_en", 32'(snap_en[0]), 32'd1);
        chk("st_aligned_addr", 32'(snap_addr[0]), 32'd4);
        chk("st_aligned_we", 32'(snap_we[0]), 32'hF);
        chk("st_aligned_wd", snap_wd[0], 32'h11223344);

        access("st_w4", 1'b1, 32'h10, 32'h80FF0102, DM_WORD, rd);
        access("ld_byte", 1'b0, 32'h13, 32'd0, DM_BYTE, rd);
        chk("ld_byte_const", rd, 32'hFFFFFF80);
        access("ld_byteu", 1'b0, 32'h13, 32'd0, DM_BYTE_U, rd);
        chk("ld_byteu_const", rd, 32'h00000080);

        access("st_mis", 1'b1, 32'h0E, 32'hAABBCCDD, DM_WORD, rd);
        chk("st_mis_lo_addr", 32'(snap_addr[0]), 32'd3);
        chk("st_mis_lo_we", 32'(snap_we[0]), 32'hC);
        chk("st_mis_lo_wd", snap_wd[0], 32'hCCDD0000);
        chk("st_mis_hi_en", 32'(snap_en[1]), 32'd1);
        chk("st_mis_hi_addr", 32'(snap_addr[1]), 32'd4);
        chk("st_mis_hi_we", 32'(snap_we[1]), 32'h3);
        chk("st_mis_hi_wd", 32'(snap_wd[1][15:0]), 32'hAABB);

        access("st_w1", 1'b1, 32'h04, 32'h12345678, DM_WORD, rd);
        access("st_w2", 1'b1, 32'h08, 32'h00000080, DM_WORD, rd);
        access("ld_half_mis", 1'b0, 32'h07, 32'd0, DM_HALF, rd);
        chk("ld_half_mis_const", rd, 32'hFFFF8012);
        idle_cycle();

        access("st_w15", 1'b1, 32'h3C, 32'hDEADBEEF, DM_WORD, rd);
        access("st_w0", 1'b1, 32'h00, 32'h01234567, DM_WORD, rd);
        access("ld_wrap", 1'b0, 32'h3E, 32'd0, DM_WORD, rd);
        chk("ld_wrap_const", rd, 32'h4567DEAD);
        chk("ld_wrap_lo_addr", 32'(snap_addr[0]), 32'd15);
        chk("ld_wrap_hi_addr", 32'(snap_addr[1]), 32'd0);
        chk("ld_wrap_hi_en", 32'(snap_en[1]), 32'd1);

        // Reset arrives while the upper half of a split store is pending.
        cpu_if.req    = 1'b1;
        cpu_if.mem_w  = 1'b1;
        cpu_if.addr   = 32'h15;
        cpu_if.wdata  = 32'h55667788;
        cpu_if.dmtype = DM_WORD;
        @(negedge clk);
        chk("rst_mid_lo_stall", 32'(cpu_if.stall), 32'd1);
        chk("rst_mid_lo_we", 32'(sram_we), 32'hE);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_hi_en", 32'(sram_en), 32'd0);
        chk("rst_mid_hi_we", 32'(sram_we), 32'd0);
        chk("rst_mid_hi_stall", 32'(cpu_if.stall), 32'd0);
        @(posedge clk); #1;
        reset      = 1'b1;
        cpu_if.req = 1'b0;
        @(negedge clk);
        chk("rst_after_en", 32'(sram_en), 32'd0);
        chk("rst_after_we", 32'(sram_we), 32'd0);
        chk("rst_after_addr", 32'(sram_addr), 32'd0);
        chk("rst_after_wdata", sram_wdata, 32'd0);
        chk("rst_after_rdata", cpu_if.rdata, 32'd0);
        chk("rst_after_stall", 32'(cpu_if.stall), 32'd0);
        model_store(32'h15, 32'h55667788, 3);
        @(posedge clk); #1;

        for (int i = 0; i < 300; i++) begin
            access("rnd", 1'($urandom_range(0, 1)), $urandom, $urandom,
                   3'($urandom_range(0, 7)), rd);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        for (int w = 0; w < NW; w++)
            chk("mem_final", sram_mem[w],
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
